// File: rtl/vshift_operand_seq.sv
// Operand sequencer for vsrl/vsll/vsra: streams vs2/vs1 beats, replicates scalar/imm, drives shifter.
// Optional VSHIFT_STALL_CNT_EN adds stall_cnt_o (cycles with valid_o & ~ready_i, saturating).
module vshift_operand_seq #(
  parameter int VL_W      = 8,
  parameter int MAX_BEATS = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [2:0]        vsew_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [1:0]        opsel_i,
  input  logic [63:0]       scalar_i,
  input  logic [4:0]        uimm_i,
  input  logic [127:0]      vs2_data_i,
  input  logic [127:0]      vs1_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic [127:0]      a_o,
  output logic [127:0]      b_o,
  output logic [2:0]        vsew_o,
  output logic [15:0]       be_o,
  output logic              last_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
`ifdef VSHIFT_STALL_CNT_EN
  output logic [15:0]       stall_cnt_o,
`endif
  output logic              dbg_state_o
);

  localparam int BYTES_W = VL_W + 4;
  localparam int BEAT_W  = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: a beat transfers on a cycle where valid and ready are both high;
  // valid, once raised, holds its payload stable until that transfer.

  state_t               state_q, state_d;
  logic [2:0]           vsew_q, vsew_d;
  logic [1:0]           opsel_q, opsel_d;
  logic [63:0]          scalar_q, scalar_d;
  logic [4:0]           uimm_q, uimm_d;
  logic [BEAT_W-1:0]    beats_q, beats_d, issued_q, issued_d;
  logic [BYTES_W-1:0]   rem_q, rem_d;
  logic [127:0]         a_q, a_d, b_q, b_d;
  logic [15:0]          be_q, be_d;
  logic                 last_q, last_d, valid_q, valid_d;
  logic                 done_q, done_d, err_q, err_d;

  logic [BYTES_W-1:0]   bytes_calc, beats_calc;
  logic                 src_ready, accept, out_hs;

  function automatic logic [127:0] rep(input logic [63:0] v, input logic [1:0] sew);
    case (sew)
      2'd0:    return {16{v[7:0]}};
      2'd1:    return {8{v[15:0]}};
      2'd2:    return {4{v[31:0]}};
      default: return {2{v}};
    endcase
  endfunction

  assign bytes_calc = {{(BYTES_W-VL_W){1'b0}}, vl_i} << vsew_i[1:0];
  assign beats_calc = (bytes_calc + BYTES_W'(15)) >> 4;
  assign src_ready  = (state_q == RUN) && (issued_q < beats_q) && (!valid_q || ready_i);
  assign accept     = src_ready && src_valid_i;
  assign out_hs     = valid_q && ready_i;

  always_comb begin
    state_d  = state_q;
    vsew_d   = vsew_q;
    opsel_d  = opsel_q;
    scalar_d = scalar_q;
    uimm_d   = uimm_q;
    beats_d  = beats_q;
    issued_d = issued_q;
    rem_d    = rem_q;
    a_d      = a_q;
    b_d      = b_q;
    be_d     = be_q;
    last_d   = last_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (state_q == IDLE) begin
      if (start_i) begin
        if (vsew_i[2] || (opsel_i == 2'b11) || (beats_calc > BYTES_W'(MAX_BEATS))) begin
          err_d = 1'b1;
        end else if (vl_i == '0) begin
          done_d = 1'b1;
        end else begin
          state_d  = RUN;
          vsew_d   = vsew_i;
          opsel_d  = opsel_i;
          scalar_d = scalar_i;
          uimm_d   = uimm_i;
          beats_d  = beats_calc[BEAT_W-1:0];
          issued_d = '0;
          rem_d    = bytes_calc;
        end
      end
    end else begin
      if (accept) begin
        a_d = vs2_data_i;
        case (opsel_q)
          2'b01:   b_d = rep(scalar_q, vsew_q[1:0]);
          2'b10:   b_d = rep({59'b0, uimm_q}, vsew_q[1:0]);
          default: b_d = vs1_data_i;
        endcase
        be_d     = (rem_q >= BYTES_W'(16)) ? 16'hFFFF : ((16'h1 << rem_q[3:0]) - 16'h1);
        last_d   = (issued_q == beats_q - BEAT_W'(1));
        valid_d  = 1'b1;
        issued_d = issued_q + BEAT_W'(1);
        rem_d    = rem_q - BYTES_W'(16);
      end else if (out_hs) begin
        valid_d = 1'b0;
      end
      // The last beat has no accept alongside it, so valid drops above.
      if (out_hs && last_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      vsew_q   <= '0;
      opsel_q  <= '0;
      scalar_q <= '0;
      uimm_q   <= '0;
      beats_q  <= '0;
      issued_q <= '0;
      rem_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      be_q     <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsew_q   <= vsew_d;
      opsel_q  <= opsel_d;
      scalar_q <= scalar_d;
      uimm_q   <= uimm_d;
      beats_q  <= beats_d;
      issued_q <= issued_d;
      rem_q    <= rem_d;
      a_q      <= a_d;
      b_q      <= b_d;
      be_q     <= be_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef VSHIFT_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start_i) begin
      stall_d = '0;
    end else if (valid_q && !ready_i && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

  assign src_ready_o = src_ready;
  assign a_o         = a_q;
  assign b_o         = b_q;
  assign vsew_o      = vsew_q;
  assign be_o        = be_q;
  assign last_o      = last_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q == RUN) || valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/vshift_operand_seq.md
# vshift_operand_seq

Operand sequencer for vector shift instructions (vsrl/vsll/vsra, .vv/.vx/.vi) in the vector execution lane, directly upstream of the 128-bit per-element shifter. It accepts one instruction at a time, streams vs2/vs1 register-file beats in, and replicates the scalar or immediate across SEW-sized elements for .vx/.vi forms. It presents registered 128-bit operand pairs, SEW, tail byte-enables and a last flag to the shifter through a valid/ready handshake.

## Interface
- VL_W, 8, width of vl_i
- MAX_BEATS, 8, maximum 128-bit beats per instruction (LMUL=8, VLEN=128)
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  instruction issue; accepted only when busy_o=0
- vsew_i  in  3  element width, `vsew_8`/`vsew_16`/`vsew_32`/`vsew_64` = 0/1/2/3
- vl_i  in  VL_W  element count
- opsel_i  in  2  00 VV, 01 VX, 10 VI, 11 illegal
- scalar_i  in  64  rs1 value (VX)
- uimm_i  in  5  shift immediate (VI), zero-extended
- vs2_data_i, vs1_data_i  in  128  source beats
- src_valid_i  in  1  source beat valid
- src_ready_o  out  1  source beat accepted when src_valid_i & src_ready_o
- a_o, b_o  out  128  shifter operands (vs2, shift amounts)
- vsew_o  out  3  latched SEW
- be_o  out  16  byte enables (0 = tail byte)
- last_o  out  1  final beat of instruction
- valid_o  out  1  operand beat valid
- ready_i  in  1  shifter/writeback accepts beat
- busy_o  out  1  instruction in flight
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle illegal-instruction pulse

## Operation
- FSM IDLE -> RUN -> IDLE. busy_o = (state==RUN) | valid_o.
- IDLE, start_i=1: latch vsew, opsel, scalar, uimm; bytes = vl_i << vsew_i; beats = (bytes+15)>>4.
  - vsew_i>3, opsel_i=11, or beats>MAX_BEATS: err_o=1 next cycle, stay IDLE, nothing latched as valid.
  - vl_i=0: done_o=1 next cycle, stay IDLE, no beats.
  - else enter RUN; issued=0, remaining_bytes=bytes.
- RUN: src_ready_o = (issued<beats) & (~valid_o | ready_i).
- Source accept: a_o<=vs2_data_i; b_o<=vs1_data_i (VV), scalar_i[SEW-1:0] replicated (VX), {zero,uimm_i} replicated at SEW (VI); be_o<= remaining_bytes>=16 ? 16'hFFFF : (1<<remaining_bytes)-1; last_o<=(issued==beats-1); valid_o<=1; issued++, remaining_bytes-=16.
- Output handshake valid_o & ready_i without new accept: valid_o<=0. Handshake with last_o=1: done_o=1 next cycle, state IDLE.
- Holding: valid_o & ~ready_i keeps a_o/b_o/be_o/last_o/vsew_o stable.
- start_i while busy_o=1 is ignored; src_valid_i outside RUN is ignored.
- Reset (any time, incl. mid-instruction): state IDLE, all outputs 0, counters 0; partial instruction discarded.

## Timing
- start_i -> src_ready_o high earliest next cycle.
- Source accept -> valid_o next cycle (1-cycle latency).
- Throughput 1 beat/cycle with ready_i held high; simultaneous output handshake and source accept in same cycle required.
- Final handshake -> done_o next cycle; new start_i accepted the cycle done_o is high.
- err_o and done_o never both high.

## Configuration
- VSHIFT_STALL_CNT_EN defined: adds stall_cnt_o out 16, counts cycles with valid_o & ~ready_i, saturates at 16'hFFFF, clears to 0 on accepted start_i, reset 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- VV, vsew=0, vl=16, ready_i=1: one beat, a_o=vs2, b_o=vs1, be_o=FFFF, last_o=1, done_o one cycle after handshake.
- VX, vsew=2, vl=6, scalar_i=64'h1234_5678_0000_0003: beat0 b_o={4{32'h00000003}} be_o=FFFF; beat1 be_o=00FF last_o=1.
- VI, vsew=3, vl=3, uimm_i=5'd17: b_o={2{64'd17}} both beats, be_o FFFF then 00FF.
- Back-pressure: ready_i low 3 cycles mid-stream -> outputs stable, src_ready_o=0, stall_cnt_o=3 (macro on).
- vsew_i=3'd5 or vsew=3,vl=17 (beats=9) -> err_o pulse, busy_o stays 0; vl=0 -> done_o pulse only.
- rstn_i low after beat 1 of 4 -> valid_o, busy_o, src_ready_o 0 immediately; next start_i runs cleanly from beat 0.
